cam_capture: RTL and testbench

- Camera front-end on the pclk domain, directly upstream of the frame-buffer memory controller.
- Samples OV7670-style vsync/href/8-bit data and pairs bytes into RGB444 pixels.
- Emits a one-cycle pixel strobe with x/y coordinates, plus frame/line pulses and sticky error flags.
- Downstream writer uses pix_valid/pix_x/pix_y directly as write enable and address source.

---
 rtl/cam_capture_pkg.sv | 46 ++++
 rtl/cam_edge_det.sv | 28 ++
 rtl/cam_capture.sv | 217 +++++++++++++++++++++
 tb/tb_cam_capture.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture block: size defaults, FSM states,
// error bit positions and test-pattern colours.
package cam_capture_pkg;

  localparam int unsigned HWIDTH_DEF = 640;
  localparam int unsigned VWIDTH_DEF = 480;
  localparam int unsigned DWIDTH_DEF = 12;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StArm      = 3'd1,
    StWaitHref = 3'd2,
    StB0       = 3'd3,
    StB1       = 3'd4
  } cap_state_e;

  localparam int unsigned ErrOdd   = 0;
  localparam int unsigned ErrLong  = 1;
  localparam int unsigned ErrShort = 2;
  localparam int unsigned ErrFrame = 3;

  localparam logic [11:0] TpgRed     = 12'hF00;
  localparam logic [11:0] TpgGreen   = 12'h0F0;
  localparam logic [11:0] TpgBlue    = 12'h00F;
  localparam logic [11:0] TpgYellow  = 12'hFF0;
  localparam logic [11:0] TpgCyan    = 12'h0FF;
  localparam logic [11:0] TpgMagenta = 12'hF0F;
  localparam logic [11:0] TpgWhite   = 12'hFFF;
  localparam logic [11:0] TpgBlack   = 12'h000;

  function automatic logic [11:0] tpg_color(input logic [2:0] idx);
    logic [11:0] c;
    unique case (idx)
      3'd0:    c = TpgRed;
      3'd1:    c = TpgGreen;
      3'd2:    c = TpgBlue;
      3'd3:    c = TpgYellow;
      3'd4:    c = TpgCyan;
      3'd5:    c = TpgMagenta;
      3'd6:    c = TpgWhite;
      default: c = TpgBlack;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Registered input stage: one sampling flop plus a history flop, giving the
// registered level and single-cycle rise/fall pulses.
module cam_edge_det (
  input  logic pclk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sig_q, hist_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      sig_q  <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      sig_q  <= din;
      hist_q <= sig_q;
    end
  end

  assign level = sig_q;
  assign rise  = sig_q & ~hist_q;
  assign fall  = ~sig_q & hist_q;

endmodule

// File: rtl/cam_capture.sv
// OV7670-style capture: pairs camera bytes into RGB444 pixels with x/y, frame/line pulses and
// sticky errors. Define CAM_TPG_EN to add tpg_sel, which swaps pix_data for 8 colour bars.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int unsigned HWIDTH = HWIDTH_DEF,
  parameter int unsigned VWIDTH = VWIDTH_DEF,
  parameter int unsigned DWIDTH = DWIDTH_DEF
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic              err_clr,
  input  logic              vsync_cam,
  input  logic              href_cam,
  input  logic [7:0]        d_cam,
`ifdef CAM_TPG_EN
  input  logic              tpg_sel,
`endif
  output logic              pix_valid,
  output logic [DWIDTH-1:0] pix_data,
  output logic [9:0]        pix_x,
  output logic [8:0]        pix_y,
  output logic              line_done,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic [3:0]        err
);

  localparam logic [9:0] HMax = 10'(HWIDTH);
  localparam logic [8:0] VMax = 9'(VWIDTH);

  logic       vsync_r, vsync_rise, vsync_fall;
  logic       href_r, href_rise, href_fall;
  logic [7:0] d_r;

  cam_edge_det u_vsync_det (
    .pclk  (pclk),
    .rst   (rst),
    .din   (vsync_cam),
    .level (vsync_r),
    .rise  (vsync_rise),
    .fall  (vsync_fall)
  );

  cam_edge_det u_href_det (
    .pclk  (pclk),
    .rst   (rst),
    .din   (href_cam),
    .level (href_r),
    .rise  (href_rise),
    .fall  (href_fall)
  );

  cap_state_e        state_q, state_d;
  logic [9:0]        col_q, col_d;
  logic [8:0]        row_q, row_d;
  logic              row_ovf_q, row_ovf_d;
  logic [7:0]        byte0_q, byte0_d;
  logic              busy_q, busy_d;
  logic [3:0]        err_q, err_d, err_set;
  logic              pix_valid_q, pix_valid_d;
  logic [DWIDTH-1:0] pix_data_q, pix_data_d, pix_c;
  logic [9:0]        pix_x_q, pix_x_d;
  logic [8:0]        pix_y_q, pix_y_d;
  logic              line_done_q, line_done_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic              in_line, line_end, frame_end, row_full, col_full;

  assign in_line   = (state_q == StB0) || (state_q == StB1);
  // vsync rising wins over an active line: the line is closed in the same cycle.
  assign line_end  = in_line && (vsync_rise || href_fall);
  assign frame_end = vsync_rise && (in_line || (state_q == StWaitHref));
  assign row_full  = (row_q >= VMax);
  assign col_full  = (col_q >= HMax);

`ifdef CAM_TPG_EN
  logic [2:0] bar_idx;
  assign bar_idx = 3'((32'(col_q) * 32'd8) / HWIDTH);
  assign pix_c   = tpg_sel ? DWIDTH'(tpg_color(bar_idx)) : DWIDTH'({byte0_q[3:0], d_r});
`else
  assign pix_c   = DWIDTH'({byte0_q[3:0], d_r});
`endif

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    row_ovf_d     = row_ovf_q;
    byte0_d       = byte0_q;
    busy_d        = busy_q;
    pix_valid_d   = 1'b0;
    pix_data_d    = pix_data_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    line_done_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    err_set       = '0;

    unique case (state_q)
      StIdle: begin
        if (cap_en) state_d = StArm;
      end
      StArm: begin
        if (vsync_fall) begin
          frame_start_d = 1'b1;
          busy_d        = 1'b1;
          row_d         = '0;
          row_ovf_d     = 1'b0;
          state_d       = StWaitHref;
        end
      end
      StWaitHref: begin
        // Rising edge (not level) so a line already in progress at frame start is skipped.
        if (href_rise && !vsync_r) begin
          byte0_d = d_r;
          col_d   = '0;
          state_d = StB1;
        end
      end
      StB1: begin
        if (href_r && !vsync_rise) begin
          if (col_full) begin
            err_set[ErrLong] = 1'b1;
          end else begin
            col_d = col_q + 10'd1;
            if (!row_full) begin
              pix_valid_d = 1'b1;
              pix_data_d  = pix_c;
              pix_x_d     = col_q;
              pix_y_d     = row_q;
            end
          end
          state_d = StB0;
        end
      end
      StB0: begin
        if (href_r && !vsync_rise) begin
          byte0_d = d_r;
          state_d = StB1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (line_end) begin
      if (state_q == StB1) err_set[ErrOdd] = 1'b1;
      if (!col_full) err_set[ErrShort] = 1'b1;
      if (row_full) begin
        row_ovf_d = 1'b1;
      end else begin
        line_done_d = 1'b1;
        row_d       = row_q + 9'd1;
      end
      state_d = StWaitHref;
    end

    if (frame_end) begin
      frame_done_d = 1'b1;
      busy_d       = 1'b0;
      if ((row_d != VMax) || row_ovf_d) err_set[ErrFrame] = 1'b1;
      state_d = cap_en ? StArm : StIdle;
    end

    err_d = (err_clr ? 4'b0 : err_q) | err_set;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= StIdle;
      col_q         <= '0;
      row_q         <= '0;
      row_ovf_q     <= 1'b0;
      byte0_q       <= '0;
      d_r           <= '0;
      busy_q        <= 1'b0;
      err_q         <= '0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      row_ovf_q     <= row_ovf_d;
      byte0_q       <= byte0_d;
      d_r           <= d_cam;
      busy_q        <= busy_d;
      err_q         <= err_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_done_q   <= line_done_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_done   = line_done_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture with a small 4x2 frame: directed and random frames checked against a
// transaction-level model of the pixels, pulses and error flags each frame should produce.
module tb_cam_capture;

  localparam int unsigned H = 4;
  localparam int unsigned V = 2;

  logic        pclk = 1'b0;
  logic        rst, cap_en, err_clr, vsync_cam, href_cam;
  logic [7:0]  d_cam;
`ifdef CAM_TPG_EN
  logic        tpg_sel;
`endif
  logic        pix_valid, line_done, frame_start, frame_done, busy;
  logic [11:0] pix_data;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [3:0]  err;

  int          checks = 0;
  int          errors = 0;
  int          n_ld = 0;
  int          n_fs = 0;
  int          n_fd = 0;
  logic [30:0] got_q[$];
  logic [30:0] exp_q[$];
  logic [3:0]  exp_err;
  bit          tpg_on = 1'b0;

  always #5 pclk = ~pclk;

  cam_capture #(
    .HWIDTH (H),
    .VWIDTH (V),
    .DWIDTH (12)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .cap_en      (cap_en),
    .err_clr     (err_clr),
    .vsync_cam   (vsync_cam),
    .href_cam    (href_cam),
    .d_cam       (d_cam),
`ifdef CAM_TPG_EN
    .tpg_sel     (tpg_sel),
`endif
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .line_done   (line_done),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy),
    .err         (err)
  );

  // Event monitor, sampled half a cycle away from the active edge.
  always @(negedge pclk) begin
    if (pix_valid) got_q.push_back({pix_data, pix_x, pix_y});
    if (line_done) n_ld++;
    if (frame_start) n_fs++;
    if (frame_done) n_fd++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  function automatic logic [11:0] bar_color(input int x);
    logic [11:0] tbl [8];
    tbl = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF, 12'h000};
    return tbl[(x * 8) / H];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_pix_x"}, pix_x, 0);
    chk({tag, "_pix_y"}, pix_y, 0);
    chk({tag, "_line_done"}, line_done, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // One frame: blanking, nl lines of the given byte counts, then vsync rises to end it.
  task automatic run_frame(input int nl, input int nb0, input int nb1, input int nb2,
                           input bit pat, input bit armed, input bit drop_cap);
    int         nb, np, base_pix, ld0, fs0, fd0, ngot;
    logic [7:0] b[$];
    exp_q.delete();
    base_pix = got_q.size();
    ld0 = n_ld;
    fs0 = n_fs;
    fd0 = n_fd;
    vsync_cam = 1'b1;
    cyc(3);
    vsync_cam = 1'b0;
    cyc(3);
    for (int l = 0; l < nl; l++) begin
      nb = (l == 0) ? nb0 : (l == 1) ? nb1 : nb2;
      b.delete();
      for (int i = 0; i < nb; i++) begin
        b.push_back(pat ? ((i % 2 == 0) ? 8'h0A : 8'hBC) : 8'($urandom));
        href_cam = 1'b1;
        d_cam    = b[i];
        cyc(1);
      end
      href_cam = 1'b0;
      d_cam    = 8'h00;
      if (armed) begin
        np = nb / 2;
        for (int k = 0; k < np; k++) begin
          if (l < V && k < H)
            exp_q.push_back({tpg_on ? bar_color(k) : {b[2*k][3:0], b[2*k+1]}, 10'(k), 9'(l)});
        end
        if (nb % 2 != 0) exp_err[0] = 1'b1;
        if (np > H) exp_err[1] = 1'b1;
        if (np < H) exp_err[2] = 1'b1;
      end
      cyc(3);
      if (l == 0) chk("busy_mid", busy, armed);
      if (l == 0 && drop_cap) cap_en = 1'b0;
    end
    vsync_cam = 1'b1;
    cyc(6);
    if (armed && nl != V) exp_err[3] = 1'b1;
    ngot = got_q.size() - base_pix;
    chk("pix_count", ngot, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < ngot; k++)
      chk("pixel", got_q[base_pix+k], exp_q[k]);
    chk("frame_start_n", n_fs - fs0, armed);
    chk("frame_done_n", n_fd - fd0, armed);
    chk("line_done_n", n_ld - ld0, armed ? ((nl < V) ? nl : V) : 0);
    chk("err", err, exp_err);
    chk("busy_end", busy, 0);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    exp_err = 4'b0;
    chk("err_clr", err, 0);
  endtask

  initial begin
    int fs0;
    rst       = 1'b1;
    cap_en    = 1'b0;
    err_clr   = 1'b0;
    vsync_cam = 1'b1;
    href_cam  = 1'b0;
    d_cam     = 8'h00;
`ifdef CAM_TPG_EN
    tpg_sel   = 1'b0;
`endif
    exp_err   = 4'b0;
    cyc(3);
    rst = 1'b0;
    chk_all_zero("reset");

    cap_en = 1'b1;
    run_frame(2, 8, 8, 0, 1'b1, 1'b1, 1'b0);   // clean frame, 0xABC pixels
    run_frame(2, 7, 8, 0, 1'b0, 1'b1, 1'b0);   // odd + short line
    chk("err_odd_short", err, 4'b0101);
    clear_err();
    run_frame(2, 12, 8, 0, 1'b0, 1'b1, 1'b0);  // long line, next line restarts at x=0
    clear_err();
    run_frame(3, 8, 8, 8, 1'b0, 1'b1, 1'b0);   // extra line is dropped, frame count error
    chk("err_frame", err, 4'b1000);
    clear_err();

    for (int f = 0; f < 6; f++) begin
      run_frame(int'($urandom_range(1, 3)), int'($urandom_range(5, 12)),
                int'($urandom_range(5, 12)), int'($urandom_range(5, 12)), 1'b0, 1'b1, 1'b0);
    end
    clear_err();

`ifdef CAM_TPG_EN
    tpg_sel = 1'b1;
    tpg_on  = 1'b1;
    run_frame(2, 8, 8, 0, 1'b0, 1'b1, 1'b0);
    tpg_sel = 1'b0;
    tpg_on  = 1'b0;
`endif

    // cap_en dropped mid-frame: this frame completes, the next one is not captured.
    run_frame(2, 8, 8, 0, 1'b0, 1'b1, 1'b1);
    run_frame(2, 8, 8, 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a line.
    cap_en = 1'b1;
    vsync_cam = 1'b1;
    cyc(3);
    vsync_cam = 1'b0;
    cyc(3);
    for (int i = 0; i < 4; i++) begin
      href_cam = 1'b1;
      d_cam    = 8'($urandom);
      cyc(1);
    end
    rst      = 1'b1;
    href_cam = 1'b0;
    cap_en   = 1'b0;
    cyc(1);
    rst = 1'b0;
    chk_all_zero("midrst");
    fs0 = n_fs;
    vsync_cam = 1'b1;
    cyc(3);
    vsync_cam = 1'b0;
    cyc(5);
    chk("idle_after_rst", n_fs - fs0, 0);
    chk("busy_after_rst", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
